// File: rtl/key_expand_ctrl_pkg.sv
// Shared AES key-schedule definitions: key-length encodings,
// per-length Nk/Total/Nr lookups and the word/byte helpers.
package key_expand_ctrl_pkg;

   localparam logic [1:0] KEY_128 = 2'd0;
   localparam logic [1:0] KEY_192 = 2'd1;
   localparam logic [1:0] KEY_256 = 2'd2;

   // The reserved encoding falls back to AES-128.
   function automatic logic [1:0] norm_len(
      input logic [1:0] len
   );
      return (len == 2'd3) ? KEY_128 : len;
   endfunction

   function automatic logic [3:0] nk_of(
      input logic [1:0] len
   );
      unique case (len)
         KEY_192: return 4'd6;
         KEY_256: return 4'd8;
         default: return 4'd4;
      endcase
   endfunction

   function automatic logic [5:0] total_of(
      input logic [1:0] len
   );
      unique case (len)
         KEY_192: return 6'd52;
         KEY_256: return 6'd60;
         default: return 6'd44;
      endcase
   endfunction

   function automatic logic [3:0] nr_of(
      input logic [1:0] len
   );
      unique case (len)
         KEY_192: return 4'd12;
         KEY_256: return 4'd14;
         default: return 4'd10;
      endcase
   endfunction

   function automatic logic [7:0] xtime(
      input logic [7:0] b
   );
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] rot_word(
      input logic [31:0] w
   );
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/key_expand_ctrl_sub_word.sv
// aes_sub_word: combinational SubWord, four parallel byte
// lookups into the AES forward S-box.
module aes_sub_word (
   input  logic [31:0] word_i,
   output logic [31:0] word_o
);

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign word_o = {
      SBOX[word_i[31:24]],
      SBOX[word_i[23:16]],
      SBOX[word_i[15:8]],
      SBOX[word_i[7:0]]
   };

endmodule

// File: rtl/key_expand_ctrl.sv
// key_expand_ctrl: fills the 64x32 expansion register file with
// the AES-128/192/256 key schedule, one word per clock.
module key_expand_ctrl
   import key_expand_ctrl_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int WORD_W = 32
) (
   input  logic                Clk,
   input  logic                Rst,
   input  logic                Start,
   input  logic [1:0]          Key_Len,
   input  logic [8*WORD_W-1:0] Key_In,
   input  logic [WORD_W-1:0]   Out_A,
   input  logic [WORD_W-1:0]   Out_B,
   output logic [WORD_W-1:0]   Wr_Data,
   output logic [ADDR_W-1:0]   Addr_Wr,
   output logic [ADDR_W-1:0]   Addr_A,
   output logic [ADDR_W-1:0]   Addr_B,
   output logic                Busy,
   output logic                Done,
   output logic                Key_Valid,
   output logic [3:0]          Num_Rounds
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOAD   = 2'd1;
   localparam logic [1:0] S_EXPAND = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

   logic [1:0]          state_q, state_d;
   logic [ADDR_W-1:0]   i_q, i_d;
   logic [2:0]          wrap_q, wrap_d;
   logic [7:0]          rcon_q, rcon_d;
   logic [8*WORD_W-1:0] key_q, key_d;
   logic [1:0]          len_q, len_d;
   logic [3:0]          nr_q, nr_d;
   logic                kv_q, kv_d;

   logic [1:0]          len_in;
   logic [ADDR_W-1:0]   nk_a;
   logic [ADDR_W-1:0]   tot_a;
   logic [2:0]          nk_m1;
   logic                first_w;
   logic                mid_w;
   logic [31:0]         sub_in;
   logic [31:0]         sub_out;
   logic [WORD_W-1:0]   temp;

   assign len_in  = norm_len(Key_Len);
   assign nk_a    = ADDR_W'(nk_of(len_q));
   assign tot_a   = ADDR_W'(total_of(len_q));
   assign nk_m1   = 3'(nk_of(len_q) - 4'd1);
   assign first_w = (wrap_q == 3'd0);
   assign mid_w   = (nk_a == ADDR_W'(8)) &&
                    (wrap_q == 3'd4);

   assign sub_in = first_w ? rot_word(Out_A) : Out_A;

   aes_sub_word u_sub_word (
      .word_i (sub_in),
      .word_o (sub_out)
   );

   always_comb begin
      temp = Out_A;
      unique case (1'b1)
         first_w: temp = sub_out ^ {rcon_q, 24'h0};
         mid_w:   temp = sub_out;
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      wrap_d  = wrap_q;
      rcon_d  = rcon_q;
      key_d   = key_q;
      len_d   = len_q;
      nr_d    = nr_q;
      kv_d    = kv_q;
      unique case (state_q)
         S_IDLE: begin
            if (Start) begin
               key_d   = Key_In;
               len_d   = len_in;
               nr_d    = nr_of(len_in);
               i_d     = '0;
               wrap_d  = 3'd0;
               rcon_d  = 8'h01;
               kv_d    = 1'b0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            // Key words leave the top of the shift register in order.
            key_d  = key_q << WORD_W;
            i_d    = i_q + ONE_A;
            wrap_d = 3'd0;
            if (i_q == nk_a - ONE_A)
               state_d = S_EXPAND;
         end
         S_EXPAND: begin
            i_d    = i_q + ONE_A;
            wrap_d = (wrap_q == nk_m1) ? 3'd0 : wrap_q + 3'd1;
            if (first_w)
               rcon_d = xtime(rcon_q);
            if (i_q == tot_a - ONE_A) begin
               kv_d    = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         wrap_q  <= 3'd0;
         rcon_q  <= 8'h01;
         key_q   <= '0;
         len_q   <= KEY_128;
         nr_q    <= 4'd10;
         kv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         wrap_q  <= wrap_d;
         rcon_q  <= rcon_d;
         key_q   <= key_d;
         len_q   <= len_d;
         nr_q    <= nr_d;
         kv_q    <= kv_d;
      end
   end

   always_comb begin
      Wr_Data = '0;
      Addr_Wr = '0;
      Addr_A  = '0;
      Addr_B  = '0;
      unique case (state_q)
         S_LOAD: begin
            Wr_Data = key_q[8*WORD_W-1 -: WORD_W];
            Addr_Wr = i_q + ONE_A;
         end
         S_EXPAND: begin
            Addr_A  = i_q;
            Addr_B  = i_q - nk_a + ONE_A;
            Wr_Data = Out_B ^ temp;
            Addr_Wr = i_q + ONE_A;
         end
         default: ;
      endcase
   end

   assign Busy       = (state_q != S_IDLE);
   assign Done       = (state_q == S_DONE);
   assign Key_Valid  = kv_q;
   assign Num_Rounds = nr_q;

endmodule

// File: tb/tb_key_expand_ctrl.sv
// Bench for key_expand_ctrl: register-file model plus a FIPS-197
// level key-schedule reference checked every cycle.
module tb_key_expand_ctrl;

   localparam logic [255:0] K128 = {
      128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K192 = {
      192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
      64'h0};
   localparam logic [255:0] K256 =
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [31:0] SENT = 32'hdeadbeef;

   logic         Clk = 1'b0;
   logic         Rst = 1'b1;
   logic         Start = 1'b0;
   logic [1:0]   Key_Len = 2'd0;
   logic [255:0] Key_In = '0;
   logic [31:0]  Out_A, Out_B, Wr_Data;
   logic [5:0]   Addr_Wr, Addr_A, Addr_B;
   logic         Busy, Done, Key_Valid;
   logic [3:0]   Num_Rounds;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   logic [31:0] rf [64] = '{default: 32'hdeadbeef};
   logic [7:0]  sb [256];

   key_expand_ctrl dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .Start      (Start),
      .Key_Len    (Key_Len),
      .Key_In     (Key_In),
      .Out_A      (Out_A),
      .Out_B      (Out_B),
      .Wr_Data    (Wr_Data),
      .Addr_Wr    (Addr_Wr),
      .Addr_A     (Addr_A),
      .Addr_B     (Addr_B),
      .Busy       (Busy),
      .Done       (Done),
      .Key_Valid  (Key_Valid),
      .Num_Rounds (Num_Rounds)
   );

   always #5 Clk = ~Clk;

   assign Out_A = rf[Addr_A];
   assign Out_B = rf[Addr_B];

   always @(posedge Clk)
      if (Addr_Wr != 6'd0)
         rf[Addr_Wr] <= Wr_Data;

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h",
                  name, act, exp);
      end
   endtask

   // GF(2^8) arithmetic used to derive the S-box from first principles.
   function automatic logic [7:0] gmul(logic [7:0] a,
                                       logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(logic [7:0] v, int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [31:0] sub4(logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]],
              sb[w[15:8]], sb[w[7:0]]};
   endfunction

   function automatic logic [1:0] nlen(logic [1:0] l);
      return (l == 2'd3) ? 2'd0 : l;
   endfunction

   function automatic int nk_b(logic [1:0] l);
      return (l == 2'd1) ? 6 : (l == 2'd2) ? 8 : 4;
   endfunction

   function automatic logic [31:0] wd(logic [1919:0] v,
                                      int i);
      return v[1919 - 32*i -: 32];
   endfunction

   function automatic logic [1919:0] expand(logic [255:0] key,
                                            logic [1:0] len);
      logic [31:0]   w [60];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [1919:0] r;
      int nk, tot;
      nk  = nk_b(nlen(len));
      tot = 4 * (nk + 7);
      r   = '0;
      for (int i = 0; i < 60; i++) w[i] = 32'h0;
      for (int i = 0; i < nk; i++)
         w[i] = key[255 - 32*i -: 32];
      for (int i = nk; i < tot; i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            rc = 8'h01;
            for (int j = 1; j < i / nk; j++)
               rc = gmul(rc, 8'h02);
            t = sub4({t[23:0], t[31:24]}) ^ {rc, 24'h0};
         end else if (nk == 8 && i % nk == 4) begin
            t = sub4(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int i = 0; i < tot; i++)
         r[1919 - 32*i -: 32] = w[i];
      return r;
   endfunction

   // Cycle-level expectation: m_k counts cycles since acceptance.
   int            m_k = 0;
   int            m_nk = 4;
   int            m_tot = 44;
   logic [3:0]    m_nr = 4'd10;
   bit            m_kv = 1'b0;
   logic [1919:0] m_sched = '0;

   always @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         m_k  <= 0;
         m_kv <= 1'b0;
         m_nr <= 4'd10;
      end else if (m_k == 0) begin
         if (Start) begin
            m_k     <= 1;
            m_kv    <= 1'b0;
            m_nk    <= nk_b(nlen(Key_Len));
            m_tot   <= 4 * (nk_b(nlen(Key_Len)) + 7);
            m_nr    <= 4'(nk_b(nlen(Key_Len)) + 6);
            m_sched <= expand(Key_In, Key_Len);
         end
      end else if (m_k == m_tot + 1) begin
         m_k <= 0;
      end else begin
         m_k <= m_k + 1;
         if (m_k == m_tot) m_kv <= 1'b1;
      end
   end

   function automatic logic [5:0] e_aw();
      return (m_k >= 1 && m_k <= m_tot) ? 6'(m_k) : 6'd0;
   endfunction

   function automatic logic [31:0] e_wd();
      return (m_k >= 1 && m_k <= m_tot) ?
             wd(m_sched, m_k - 1) : 32'h0;
   endfunction

   function automatic logic [5:0] e_aa();
      return (m_k > m_nk && m_k <= m_tot) ? 6'(m_k - 1) : 6'd0;
   endfunction

   function automatic logic [5:0] e_ab();
      return (m_k > m_nk && m_k <= m_tot) ? 6'(m_k - m_nk) : 6'd0;
   endfunction

   function automatic int rf_bad();
      int bad;
      bad = 0;
      for (int i = 0; i < m_tot; i++)
         if (rf[i+1] !== wd(m_sched, i)) bad++;
      return bad;
   endfunction

   always @(negedge Clk) begin
      if (chk_en) begin
         chk("Busy", Busy, m_k != 0);
         chk("Done", Done, m_k == m_tot + 1);
         chk("Key_Valid", Key_Valid, m_kv);
         chk("Num_Rounds", Num_Rounds, m_nr);
         chk("Addr_Wr", Addr_Wr, e_aw());
         chk("Wr_Data", Wr_Data, e_wd());
         chk("Addr_A", Addr_A, e_aa());
         chk("Addr_B", Addr_B, e_ab());
         if (m_k == m_tot + 1)
            chk("rf_schedule_bad_words", rf_bad(), 0);
      end
   end

   task automatic run(input logic [255:0] key,
                      input logic [1:0] len,
                      input int repulse,
                      input int exp_edges,
                      input logic [3:0] exp_nr,
                      input string tag);
      int n;
      int dones;
      bit seen;
      @(posedge Clk); #1;
      Start = 1'b1; Key_In = key; Key_Len = len;
      @(posedge Clk); #1;
      Start = 1'b0; Key_In = ~key;
      chk({tag, "_nr"}, Num_Rounds, exp_nr);
      n = 0; dones = 0; seen = 1'b0;
      while (!seen && n < 200) begin
         @(negedge Clk);
         n++;
         if (Done) begin
            seen = 1'b1;
            dones++;
         end
         if (n == repulse) begin
            Start = 1'b1; Key_In = K256; Key_Len = 2'd2;
         end else if (n == repulse + 1) begin
            Start = 1'b0;
         end
      end
      chk({tag, "_done_seen"}, seen, 1);
      chk({tag, "_done_edge"}, n - 1, exp_edges);
      repeat (3) begin
         @(negedge Clk);
         if (Done) dones++;
      end
      chk({tag, "_done_pulses"}, dones, 1);
      chk({tag, "_kv_held"}, Key_Valid, 1);
      chk({tag, "_idle"}, Busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^
                 rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
      chk("pin_sbox_00", sb[0], 8'h63);
      chk("pin128_w4", wd(expand(K128, 0), 4), 32'ha0fafe17);
      chk("pin128_w43", wd(expand(K128, 0), 43), 32'hb6630ca6);
      chk("pin192_w6", wd(expand(K192, 1), 6), 32'hfe0c91f7);
      chk("pin192_w51", wd(expand(K192, 1), 51), 32'h01002202);
      chk("pin256_w8", wd(expand(K256, 2), 8), 32'h9ba35411);
      chk("pin256_w12", wd(expand(K256, 2), 12), 32'ha8b09c1a);
      chk("pin256_w59", wd(expand(K256, 2), 59), 32'h706c631e);

      #1 Rst = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_Busy", Busy, 0);
      chk("rst_Done", Done, 0);
      chk("rst_Key_Valid", Key_Valid, 0);
      chk("rst_Num_Rounds", Num_Rounds, 4'd10);
      chk("rst_Addr_Wr", Addr_Wr, 0);
      chk("rst_Wr_Data", Wr_Data, 0);
      chk("rst_Addr_A", Addr_A, 0);
      chk("rst_Addr_B", Addr_B, 0);
      chk_en = 1'b1;
      @(negedge Clk);
      Rst = 1'b1;

      run(K128, 2'd0, -1, 44, 4'd10, "aes128");
      chk("aes128_reg5", rf[5], 32'ha0fafe17);
      chk("aes128_reg44", rf[44], 32'hb6630ca6);

      run(K192, 2'd1, -1, 52, 4'd12, "aes192");
      chk("aes192_reg7", rf[7], 32'hfe0c91f7);
      chk("aes192_reg52", rf[52], 32'h01002202);

      run(K256, 2'd2, -1, 60, 4'd14, "aes256");
      chk("aes256_reg9", rf[9], 32'h9ba35411);
      chk("aes256_reg13", rf[13], 32'ha8b09c1a);
      chk("aes256_reg60", rf[60], 32'h706c631e);

      run(K128, 2'd0, 10, 44, 4'd10, "restart_ign");
      chk("restart_reg5", rf[5], 32'ha0fafe17);
      chk("restart_reg44", rf[44], 32'hb6630ca6);

      @(posedge Clk); #1;
      Start = 1'b1; Key_In = K256; Key_Len = 2'd2;
      @(posedge Clk); #1;
      Start = 1'b0;
      repeat (20) @(posedge Clk);
      chk("abort_busy_before", Busy, 1);
      #2 Rst = 1'b0;
      #1;
      chk("abort_Busy", Busy, 0);
      chk("abort_Key_Valid", Key_Valid, 0);
      chk("abort_Addr_Wr", Addr_Wr, 0);
      chk("abort_Done", Done, 0);
      repeat (2) @(negedge Clk);
      Rst = 1'b1;
      run(K128, 2'd0, -1, 44, 4'd10, "after_abort");
      chk("after_abort_reg44", rf[44], 32'hb6630ca6);

      run(K128, 2'd3, -1, 44, 4'd10, "len3");
      chk("len3_reg5", rf[5], 32'ha0fafe17);
      chk("len3_reg44", rf[44], 32'hb6630ca6);

      for (int c = 0; c < 700; c++) begin
         @(posedge Clk); #1;
         Start = ($urandom_range(0, 3) == 0);
         Key_Len = 2'($urandom_range(0, 3));
         for (int k = 0; k < 8; k++)
            Key_In[32*k +: 32] = $urandom();
      end
      @(posedge Clk); #1;
      Start = 1'b0;
      n = 0;
      while (Busy && n < 100) begin
         @(negedge Clk);
         n++;
      end
      chk("random_drain", Busy, 0);

      chk("reg0_untouched", rf[0], SENT);
      chk("reg61_untouched", rf[61], SENT);
      chk("reg62_untouched", rf[62], SENT);
      chk("reg63_untouched", rf[63], SENT);

      @(negedge Clk);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
